// File: rtl/spram_access_ctrl.sv
// Single-port RAM front-end: write/read arbitration, 2-entry read response FIFO.
// Optional power-up init sweep of the RAM is enabled by defining SPRAM_ACCESS_INIT_EN.
module spram_access_ctrl #(
    parameter int unsigned     DW       = 8,
    parameter int unsigned     AW       = 3,
    parameter int unsigned     DEPTH    = 8,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          init_done
);

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CW         = 2;
    localparam int unsigned SW         = CW + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef SPRAM_ACCESS_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
`else
    localparam state_t RST_STATE = ST_RUN;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   init_addr;
    logic            init_last;
    logic            last_rd;
    logic            inflight;
    logic            rd_elig;
    logic            wr_gnt;
    logic            rd_gnt;
    logic            push;
    logic            pop;
    logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
    logic            fifo_rp;
    logic            fifo_wp;
    logic [CW-1:0]   fifo_cnt;

    assign init_last = (init_addr == AW'(DEPTH - 1));

    // A read needs a FIFO slot reserved for itself and any read still in flight.
    assign rd_elig = (SW'(fifo_cnt) + SW'(inflight)) < SW'(FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_last) begin
            state_nxt = ST_RUN;
        end
    end

    // Grant selection and RAM port drive; a tie goes to the side not served last.
    always_comb begin
        wr_gnt  = 1'b0;
        rd_gnt  = 1'b0;
        ram_ce  = 1'b0;
        ram_we  = 1'b0;
        ram_adr = '0;
        ram_din = '0;
        if (!rst) begin
            if (state == ST_INIT) begin
                ram_ce  = 1'b1;
                ram_we  = 1'b1;
                ram_adr = init_addr;
                ram_din = INIT_VAL;
            end else begin
                if (wr_valid && rd_valid && rd_elig) begin
                    wr_gnt = last_rd;
                    rd_gnt = !last_rd;
                end else begin
                    wr_gnt = wr_valid;
                    rd_gnt = rd_valid && rd_elig;
                end
                if (wr_gnt) begin
                    ram_ce  = 1'b1;
                    ram_we  = 1'b1;
                    ram_adr = wr_addr;
                    ram_din = wr_data;
                end else if (rd_gnt) begin
                    ram_ce  = 1'b1;
                    ram_adr = rd_addr;
                end
            end
        end
    end

    assign wr_ready  = wr_gnt;
    assign rd_ready  = rd_gnt;
    assign init_done = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            init_addr <= '0;
        end else if (state == ST_INIT) begin
            init_addr <= init_addr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            last_rd  <= 1'b1;
        end else begin
            inflight <= rd_gnt;
            if (wr_gnt || rd_gnt) begin
                last_rd <= rd_gnt;
            end
        end
    end

    // RAM read data arrives one cycle after the read grant.
    assign push      = inflight;
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[fifo_rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rp  <= 1'b0;
            fifo_wp  <= 1'b0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[fifo_wp] <= ram_dout;
                fifo_wp           <= ~fifo_wp;
            end
            if (pop) begin
                fifo_rp <= ~fifo_rp;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Bench for spram_access_ctrl: RAM model, response scoreboard, vector table and
// hand-written reset / latency / ordering sequences.
module tb_spram_access_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '1;
    logic          init_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit arb_chk  = 1'b0;

    logic [DW-1:0] ram_mem [DEPTH] = '{default: 8'hFF};
    logic [DW-1:0] exp_mem [DEPTH] = '{default: 8'hFF};
    logic [DW-1:0] sb [$];

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AW-1:0] ra;
        logic          rr;
        logic          ew;
        logic          er;
    } vec_t;
    vec_t tbl [$];

    spram_access_ctrl #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .INIT_VAL(8'h00)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
        .ram_dout(ram_dout), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read data, contents power up as all ones.
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                ram_mem[ram_adr] <= ram_din;
            end else begin
                ram_dout <= ram_mem[ram_adr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
`ifdef SPRAM_ACCESS_INIT_EN
            for (int i = 0; i < DEPTH; i++) exp_mem[i] <= 8'h00;
`endif
        end else begin
            if (arb_chk) begin
                check("one_grant", 32'(wr_ready & rd_ready), 32'(0));
                check("ram_ce", 32'(ram_ce), 32'(wr_ready | rd_ready));
                if (rd_ready) check("credit", 32'(sb.size() < 2), 32'(1));
                if (wr_ready) check("ram_wr_port", 32'({ram_we, ram_adr, ram_din}), 32'({1'b1, wr_addr, wr_data}));
                if (rd_ready) check("ram_rd_port", 32'({ram_we, ram_adr}), 32'({1'b0, rd_addr}));
            end
            if (wr_valid && wr_ready) exp_mem[wr_addr] <= wr_data;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'(0));
                else check("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
            end
            if (rd_valid && rd_ready) sb.push_back(exp_mem[rd_addr]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input int wa, input int wd,
                         input logic rv, input int ra, input logic rr);
        wr_valid  = wv;
        wr_addr   = AW'(wa);
        wr_data   = DW'(wd);
        rd_valid  = rv;
        rd_addr   = AW'(ra);
        rsp_ready = rr;
    endtask

    task automatic add(input logic wv, input int wa, input int wd, input logic rv,
                       input int ra, input logic rr, input logic ew, input logic er);
        vec_t v;
        v.wv = wv; v.wa = AW'(wa); v.wd = DW'(wd);
        v.rv = rv; v.ra = AW'(ra); v.rr = rr;
        v.ew = ew; v.er = er;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] exp3;

        // Arbitration/backpressure table, one row per cycle.
        add(1,3,8'hA5, 0,0, 1, 1,0);
        add(0,0,0,     1,3, 1, 0,1);
        add(0,0,0,     0,0, 1, 0,0);
        add(1,5,8'h3C, 1,3, 1, 1,0);
        add(1,6,8'h77, 1,3, 1, 0,1);
        add(1,6,8'h77, 1,5, 1, 1,0);
        add(1,7,8'h11, 1,5, 1, 0,1);
        add(1,7,8'h11, 1,6, 1, 1,0);
        add(1,0,8'h22, 1,6, 1, 0,1);
        add(1,0,8'h22, 0,0, 1, 1,0);
        add(0,0,0,     0,0, 1, 0,0);
        add(0,0,0,     0,0, 1, 0,0);
        add(0,0,0,     1,0, 0, 0,1);
        add(0,0,0,     1,3, 0, 0,1);
        add(1,1,8'h33, 1,5, 0, 1,0);
        add(1,2,8'h44, 1,5, 0, 1,0);
        add(0,0,0,     1,5, 0, 0,0);
        add(0,0,0,     1,5, 1, 0,0);
        add(0,0,0,     1,5, 1, 0,1);
        add(0,0,0,     1,6, 1, 0,1);
        add(0,0,0,     0,0, 1, 0,0);
        add(0,0,0,     0,0, 1, 0,0);
        add(0,0,0,     0,0, 1, 0,0);
        add(0,0,0,     1,0, 1, 0,1);
        add(0,0,0,     1,1, 1, 0,1);
        add(0,0,0,     1,2, 1, 0,0);
        add(0,0,0,     1,2, 1, 0,1);
        add(0,0,0,     1,3, 1, 0,1);
        add(0,0,0,     1,4, 1, 0,0);
        add(0,0,0,     1,4, 1, 0,1);
        add(0,0,0,     1,5, 1, 0,1);
        add(0,0,0,     0,0, 1, 0,0);
        add(0,0,0,     0,0, 1, 0,0);
        add(0,0,0,     0,0, 1, 0,0);

        // Reset values
        drive(0,0,0, 0,0, 0);
        rst = 1'b1;
        repeat (3) cyc();
        #1;
        check("rst_wr_ready", 32'(wr_ready), 32'(0));
        check("rst_rd_ready", 32'(rd_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_ram_ce_we", 32'({ram_ce, ram_we}), 32'(0));
        check("rst_ram_adr_din", 32'({ram_adr, ram_din}), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
`ifdef SPRAM_ACCESS_INIT_EN
        check("rst_init_done", 32'(init_done), 32'(0));
        cyc();
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive(1,5,8'h5A, 1,2, 1);
            #1;
            check("init_ram_op", 32'({ram_ce, ram_we, ram_adr, ram_din}), 32'({1'b1, 1'b1, AW'(k), 8'h00}));
            check("init_no_grant", 32'({wr_ready, rd_ready}), 32'(0));
            check("init_done_low", 32'(init_done), 32'(0));
            cyc();
        end
        drive(0,0,0, 0,0, 1);
        #1;
        check("init_done_high", 32'(init_done), 32'(1));
`else
        check("rst_init_done", 32'(init_done), 32'(1));
        cyc();
        rst = 1'b0;
        drive(0,0,0, 0,0, 1);
        #1;
        check("run_init_done", 32'(init_done), 32'(1));
`endif
        arb_chk = 1'b1;
        cyc();

        // Write then read the same address: data returns two cycles after the read grant.
        drive(1,3,8'hA5, 0,0, 1);
        #1; check("lat_wr_grant", 32'(wr_ready), 32'(1));
        cyc();
        drive(0,0,0, 1,3, 1);
        #1; check("lat_rd_grant", 32'(rd_ready), 32'(1));
        check("lat_rsp_g0", 32'(rsp_valid), 32'(0));
        cyc();
        drive(0,0,0, 0,0, 1);
        #1; check("lat_rsp_g1", 32'(rsp_valid), 32'(0));
        cyc();
        #1; check("lat_rsp_g2", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'hA5}));
        cyc();
        #1; check("lat_rsp_g3", 32'(rsp_valid), 32'(0));
        cyc();
        cyc();

        foreach (tbl[i]) begin
            drive(tbl[i].wv, int'(tbl[i].wa), int'(tbl[i].wd), tbl[i].rv, int'(tbl[i].ra), tbl[i].rr);
            #1;
            check($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].ew));
            check($sformatf("vec%0d_rd_ready", i), 32'(rd_ready), 32'(tbl[i].er));
            cyc();
        end

        // Reset with one response queued and one read in flight.
        drive(0,0,0, 1,3, 0);
        #1; check("mid_rd0", 32'(rd_ready), 32'(1));
        cyc();
        drive(0,0,0, 1,4, 0);
        #1; check("mid_rd1", 32'(rd_ready), 32'(1));
        cyc();
        arb_chk = 1'b0;
        drive(0,0,0, 0,0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(0,0,0, 0,0, 1);
        for (int k = 0; k < 40 && !init_done; k++) cyc();
        check("mid_init_done", 32'(init_done), 32'(1));
        arb_chk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; check("mid_no_stale_rsp", 32'(rsp_valid), 32'(0));
            cyc();
        end

        // After reset a write wins the first tie, then the read.
        exp3 = exp_mem[3];
        drive(1,2,8'h99, 1,3, 1);
        #1; check("post_tie0", 32'({wr_ready, rd_ready}), 32'(2'b10));
        cyc();
        drive(1,5,8'h66, 1,3, 1);
        #1; check("post_tie1", 32'({wr_ready, rd_ready}), 32'(2'b01));
        cyc();
        drive(1,5,8'h66, 0,0, 1);
        #1; check("post_wr", 32'({wr_ready, rsp_valid}), 32'(2'b10));
        cyc();
        drive(0,0,0, 0,0, 1);
        #1; check("post_rsp", 32'({rsp_valid, rsp_data}), 32'({1'b1, exp3}));
        cyc();
        #1; check("post_rsp_end", 32'(rsp_valid), 32'(0));
        repeat (3) cyc();
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
